// File: rtl/ws2812_frame_arbiter.sv
// ws2812_frame_arbiter: shares one WS2812 serializer between three colour sources, with periodic refresh
// Ports:
//   clk, rst            - 50 MHz clock, asynchronous active-low reset
//   req_i[2:0]          - level requests; bit 2 is the alarm and always wins
//   color0_i..color2_i  - GRB colour per source, sampled in the GRANT cycle
//   ser_done_i          - serializer frame-complete pulse
//   grant_o             - one-hot pulse naming the latched source (zero for refresh)
//   busy_o              - high from GRANT until the latch gap ends
//   ser_start_o         - serializer start pulse
//   ser_color_o         - latched colour, stable while busy
//   cur_src_o           - source of the current/last frame, 3 = refresh
//   err_o               - sticky serializer timeout flag
//   frame_count_o       - completed frames, wrapping
module ws2812_frame_arbiter #(
  parameter int RESET_CYCLES   = 3000,
  parameter int REFRESH_CYCLES = 25_000_000,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_i,
  input  logic [23:0] color0_i,
  input  logic [23:0] color1_i,
  input  logic [23:0] color2_i,
  input  logic        ser_done_i,
  output logic [2:0]  grant_o,
  output logic        busy_o,
  output logic        ser_start_o,
  output logic [23:0] ser_color_o,
  output logic [1:0]  cur_src_o,
  output logic        err_o,
  output logic [7:0]  frame_count_o
);
  localparam int MAX_RT = REFRESH_CYCLES > TIMEOUT_CYCLES ? REFRESH_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_C  = MAX_RT > RESET_CYCLES ? MAX_RT : RESET_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);
  typedef enum logic [2:0] {IDLE, GRANT, START, WAIT_DONE, GAP} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    src_q;
  logic [1:0]    win_d;
  logic          rr_q;
  logic          valid_q;
  // the refresh, timeout and gap counts live in mutually exclusive states, so one counter serves all three
  always_comb win_d = req_i[2] ? 2'd2 : (req_i[1] & (~req_i[0] | rr_q)) ? 2'd1 : 2'd0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      src_q         <= '0;
      rr_q          <= 1'b0;
      valid_q       <= 1'b0;
      grant_o       <= '0;
      busy_o        <= 1'b0;
      ser_start_o   <= 1'b0;
      ser_color_o   <= '0;
      cur_src_o     <= '0;
      err_o         <= 1'b0;
      frame_count_o <= '0;
    end else begin
      grant_o     <= '0;
      ser_start_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i != 3'b000) begin
            state_q <= GRANT;
            cnt_q   <= '0;
            src_q   <= win_d;
            grant_o <= 3'b001 << win_d;
            busy_o  <= 1'b1;
            if (!req_i[2]) rr_q <= ~win_d[0];
          end else if (valid_q && cnt_q == CW'(REFRESH_CYCLES - 1)) begin
            state_q <= GRANT;
            cnt_q   <= '0;
            src_q   <= 2'd3;
            busy_o  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        GRANT: begin
          state_q     <= START;
          cur_src_o   <= src_q;
          ser_start_o <= 1'b1;
          if (src_q != 2'd3) ser_color_o <= src_q == 2'd2 ? color2_i : src_q == 2'd1 ? color1_i : color0_i;
        end
        START: begin
          state_q <= WAIT_DONE;
          cnt_q   <= '0;
        end
        WAIT_DONE: begin
          if (ser_done_i) begin
            state_q       <= GAP;
            cnt_q         <= '0;
            valid_q       <= 1'b1;
            frame_count_o <= frame_count_o + 8'd1;
          end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_q <= GAP;
            cnt_q   <= '0;
            err_o   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        GAP: begin
          if (cnt_q == CW'(RESET_CYCLES - 1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_o  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ws2812_frame_arbiter.sv
// tb_ws2812_frame_arbiter: directed self-checking bench for ws2812_frame_arbiter
module tb_ws2812_frame_arbiter;
  localparam logic [23:0] C0 = 24'h00FF00;
  localparam logic [23:0] C1 = 24'h123456;
  localparam logic [23:0] C2 = 24'hABCDEF;
  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [23:0] color0, color1, color2;
  logic        ser_done;
  logic [2:0]  grant;
  logic        busy, ser_start, err;
  logic [23:0] ser_color;
  logic [1:0]  cur_src;
  logic [7:0]  frame_count;
  int nerr = 0;
  int nchk = 0;
  int n;
  ws2812_frame_arbiter #(.RESET_CYCLES(4), .REFRESH_CYCLES(20), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .req_i(req), .color0_i(color0), .color1_i(color1), .color2_i(color2),
    .ser_done_i(ser_done), .grant_o(grant), .busy_o(busy), .ser_start_o(ser_start),
    .ser_color_o(ser_color), .cur_src_o(cur_src), .err_o(err), .frame_count_o(frame_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // waits for ser_start, checks the frame it announces, then either answers with ser_done after dly
  // cycles or (dly<0) withholds it and measures the timeout; returns on the first IDLE cycle
  task automatic serve(input logic [2:0] eg, input logic [1:0] es, input logic [23:0] ec,
                       input int dly, input logic [2:0] mreq, input string tag);
    logic [2:0] g;
    int m;
    g = '0;
    m = 0;
    while (!ser_start && m < 200) begin
      if (grant != 3'b000) g = grant;
      tick(1);
      m++;
    end
    chk({tag, "_start"}, 64'(m < 200), 64'd1);
    chk({tag, "_grant"}, 64'(g), 64'(eg));
    chk({tag, "_src"}, 64'(cur_src), 64'(es));
    chk({tag, "_color"}, 64'(ser_color), 64'(ec));
    req = mreq;
    if (dly < 0) begin
      m = 0;
      while (!err && m < 200) begin
        tick(1);
        m++;
      end
      chk({tag, "_tmo_cycles"}, 64'(m), 64'd51);
    end else begin
      tick(dly);
      ser_done = 1'b1;
      tick(1);
      ser_done = 1'b0;
    end
    m = 0;
    while (busy && m < 200) begin
      tick(1);
      m++;
    end
    chk({tag, "_gap_end"}, 64'(m < 200), 64'd1);
  endtask
  initial begin
    rst = 1'b1; req = '0; ser_done = 1'b0;
    color0 = C0; color1 = C1; color2 = C2;
    #2 rst = 1'b0;
    tick(2);
    chk("reset_outs", {grant, busy, ser_start, ser_color, cur_src, err, frame_count}, 64'd0);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (ser_start) n++;
    end
    chk("no_refresh_before_frame", 64'(n), 64'd0);
    req = 3'b001;
    tick(1);
    chk("t1_grant", 64'(grant), 64'b001);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_start_early", 64'(ser_start), 64'd0);
    req = 3'b000;
    tick(1);
    chk("t1_start", 64'(ser_start), 64'd1);
    chk("t1_color", 64'(ser_color), 64'(C0));
    chk("t1_src", 64'(cur_src), 64'd0);
    chk("t1_grant_drop", 64'(grant), 64'd0);
    tick(1);
    chk("t1_start_pulse", 64'(ser_start), 64'd0);
    tick(9);
    ser_done = 1'b1;
    tick(1);
    ser_done = 1'b0;
    chk("t1_count", 64'(frame_count), 64'd1);
    tick(3);
    chk("t1_busy_gap", 64'(busy), 64'd1);
    tick(1);
    chk("t1_busy_fall", 64'(busy), 64'd0);
    req = 3'b001;
    tick(3);
    req = 3'b000;
    rst = 1'b0;
    #1;
    chk("midframe_reset", {grant, busy, ser_start, ser_color, cur_src, err, frame_count}, 64'd0);
    tick(1);
    rst = 1'b1;
    tick(1);
    req = 3'b011;
    serve(3'b001, 2'd0, C0, 3, 3'b011, "rr1");
    serve(3'b010, 2'd1, C1, 3, 3'b011, "rr2");
    serve(3'b001, 2'd0, C0, 3, 3'b011, "rr3");
    serve(3'b010, 2'd1, C1, 3, 3'b000, "rr4");
    chk("rr_count", 64'(frame_count), 64'd4);
    req = 3'b110;
    serve(3'b100, 2'd2, C2, 3, 3'b110, "al1");
    serve(3'b100, 2'd2, C2, 3, 3'b010, "al2");
    serve(3'b010, 2'd1, C1, 3, 3'b110, "al3");
    serve(3'b100, 2'd2, C2, 3, 3'b000, "al4");
    chk("al_count", 64'(frame_count), 64'd8);
    for (int r = 0; r < 2; r++) begin
      n = 0;
      while (!busy && n < 100) begin
        tick(1);
        n++;
      end
      chk("refresh_idle_cycles", 64'(n), 64'd20);
      serve(3'b000, 2'd3, C2, 3, 3'b000, "refresh");
    end
    chk("refresh_count", 64'(frame_count), 64'd10);
    req = 3'b001;
    serve(3'b001, 2'd0, C0, 50, 3'b000, "done_at_tmo");
    chk("done_at_tmo_err", 64'(err), 64'd0);
    chk("done_at_tmo_count", 64'(frame_count), 64'd11);
    req = 3'b010;
    serve(3'b010, 2'd1, C1, -1, 3'b000, "tmo");
    chk("tmo_count", 64'(frame_count), 64'd11);
    chk("tmo_err", 64'(err), 64'd1);
    req = 3'b001;
    serve(3'b001, 2'd0, C0, 3, 3'b000, "after_tmo");
    chk("after_tmo_count", 64'(frame_count), 64'd12);
    chk("err_sticky", 64'(err), 64'd1);
    rst = 1'b0;
    #1 rst = 1'b1;
    tick(1);
    req = 3'b001;
    for (int i = 0; i < 256; i++) begin
      serve(3'b001, 2'd0, C0, 1, (i == 255) ? 3'b000 : 3'b001, "wrap");
      if (i == 254) chk("wrap_255", 64'(frame_count), 64'd255);
    end
    chk("wrap_0", 64'(frame_count), 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/ws2812_frame_arbiter.md
Name: ws2812_frame_arbiter

Overview:
- Shares one WS2812 bit-serializer between three colour requesters: req0 temperature colour, req1 button pattern, req2 alarm.
- Arbitrates among pending requests and latches the winner's 24-bit GRB colour.
- Starts the serializer and waits for its done pulse, then enforces the strip latch/reset gap.
- When no request is pending, periodically re-sends the last frame. Sits between the sensor/UI logic and the ws2812 serializer on the DE2 board.

Parameters:
- RESET_CYCLES, 3000, idle clocks after ser_done before the next ser_start (≥50 us @ 50 MHz).
- REFRESH_CYCLES, 25_000_000, idle clocks before the last frame is re-sent (0.5 s).
- TIMEOUT_CYCLES, 1_000_000, maximum clocks waiting for ser_done before the frame is aborted.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-low reset
- req  in  3  level request per source; bit2 = alarm
- color0  in  24  GRB colour, source 0
- color1  in  24  GRB colour, source 1
- color2  in  24  GRB colour, source 2
- ser_done  in  1  one-cycle pulse from the serializer when the frame has been shifted out
- grant  out  3  one-hot, one-cycle pulse naming the source whose colour was latched
- busy  out  1  high from the grant cycle until GAP exits
- ser_start  out  1  one-cycle pulse that starts the serializer
- ser_color  out  24  latched colour; stable while busy
- cur_src  out  2  source of the current/last frame: 0-2, or 3 = refresh
- err  out  1  sticky timeout flag; cleared only by reset
- frame_count  out  8  frames completed, wraps 255→0

Behaviour:
- Reset (asynchronous, active-low) forces state IDLE and all outputs to 0: grant, busy, ser_start, ser_color, cur_src, err, frame_count.
- Reset also clears the round-robin pointer (rr=0, favouring source 0), the valid-frame flag, and all counters.
- States: IDLE, GRANT, START, WAIT_DONE, GAP.
- IDLE:
  - Refresh counter increments each cycle.
  - If req≠0: go to GRANT next cycle and clear the refresh counter.
  - Else if a frame has ever been sent and refresh counter reaches REFRESH_CYCLES-1: go to GRANT as a refresh.
- Arbitration, evaluated in IDLE:
  - req[2] has fixed highest priority.
  - Otherwise sources 0 and 1 alternate round-robin; rr points to the favoured one. If only one of them requests, it wins.
  - After a 0/1 win, rr points to the other source. Alarm grants do not move rr.
- GRANT (1 cycle):
  - Latch the winner's colour into ser_color and set cur_src.
  - Pulse the winner's grant bit and set busy=1.
  - Refresh frames keep ser_color, set cur_src=3, and pulse no grant bit.
  - The colour is sampled in this cycle; requesters must hold colorN valid while req is high.
- START (1 cycle): ser_start=1. Clear the timeout counter.
- WAIT_DONE:
  - On ser_done: frame_count+1, set the valid-frame flag, go to GAP.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 without ser_done: set err, go to GAP; frame_count is unchanged.
  - ser_done outside WAIT_DONE is ignored.
- GAP:
  - Count RESET_CYCLES clocks, then go to IDLE and drop busy.
  - The earliest new ser_start is RESET_CYCLES+3 cycles after ser_done.
- Latency: req rising in IDLE → grant at +1 cycle → ser_start at +2 cycles.
- Requests arriving while busy stay pending (req is level-sensitive) and are arbitrated on return to IDLE.
- A request that is still held after its grant is served again, subject to round-robin.
- Simultaneous events:
  - Request and refresh expiry in the same cycle: the request wins.
  - ser_done and timeout in the same cycle: ser_done wins; err is not set.
- Reset mid-frame: return to IDLE immediately. ser_start must not glitch high.

Test Plan:
- Params RESET_CYCLES=4, REFRESH_CYCLES=20, TIMEOUT_CYCLES=50. Pulse req0 with color0=24'h00FF00 → grant=3'b001 at +1, ser_start at +2, ser_color=24'h00FF00, cur_src=0. ser_done 10 cycles later → frame_count=1; busy falls 5 cycles after ser_done.
- Hold req0 and req1 together for 4 frames → grant sequence 001, 010, 001, 010.
- Assert req2 and req1 together; also assert req2 mid-frame with req1 held → alarm served first; after GAP, req2 wins over req1 every time it is asserted.
- No requests after the first frame → ser_start repeats every 20 IDLE cycles with cur_src=3, grant=0, ser_color unchanged. No ser_start before any frame has been sent.
- Withhold ser_done → err=1 after 50 cycles in WAIT_DONE, frame_count unchanged, next req still served. Also assert ser_done on the timeout cycle → err stays 0.
- Assert rst low during WAIT_DONE → all outputs 0 immediately. Run 256 frames → frame_count wraps to 0.
